// File: rtl/fram_ctrl_pkg.sv
// Shared types and constants for the FM28V102A parallel F-RAM controller.
// Holds the FSM state encoding, default timing and bus widths.
package fram_ctrl_pkg;

  localparam int FRAM_AW = 16;
  localparam int FRAM_DW = 16;

  localparam int TAS_CYC_DEF = 1;
  localparam int TCA_CYC_DEF = 7;
  localparam int TPC_CYC_DEF = 6;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    ACCESS,
    HOLD,
    PRECHARGE
  } state_t;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/fram_ctrl_if.sv
// Host-side request/response bus of the F-RAM controller.
// master = requester, slave = controller.
interface fram_ctrl_if;
  import fram_ctrl_pkg::*;

  logic               req_valid;
  logic               req_ready;
  logic               req_we;
  logic [FRAM_AW-1:0] req_addr;
  logic [FRAM_DW-1:0] req_wdata;
  logic [1:0]         req_be;
  logic               rsp_valid;
  logic [FRAM_DW-1:0] rsp_rdata;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_be,
    input  req_ready, rsp_valid, rsp_rdata
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_be,
    output req_ready, rsp_valid, rsp_rdata
  );

endinterface

// File: rtl/fram_cyc_timer.sv
// Loadable down-counter shared by all timed controller states.
// A load of (n-1) keeps done low for n-1 cycles, so the owning state lasts n cycles.
module fram_cyc_timer #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         done
);

  logic [W-1:0] count_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      count_reg <= '0;
    end else if (load) begin
      count_reg <= load_val;
    end else if (count_reg != '0) begin
      count_reg <= count_reg - W'(1);
    end
  end

  assign done = (count_reg == '0);

endmodule

// File: rtl/fram_ctrl.sv
// Host-side controller for the 64Kx16 FM28V102A F-RAM: one valid/ready request
// becomes one timed CE/WE/OE bus cycle; all device pins come straight from flops.
module fram_ctrl
  import fram_ctrl_pkg::*;
#(
  parameter int TAS_CYC = TAS_CYC_DEF,
  parameter int TCA_CYC = TCA_CYC_DEF,
  parameter int TPC_CYC = TPC_CYC_DEF
) (
  input  logic               clk,
  input  logic               rst,
  fram_ctrl_if.slave         bus,
  output logic               fram_ce_n,
  output logic               fram_we_n,
  output logic               fram_oe_n,
  output logic               fram_ub_n,
  output logic               fram_lb_n,
  output logic [FRAM_AW-1:0] fram_addr,
  output logic [FRAM_DW-1:0] fram_dq_o,
  output logic               fram_dq_oe,
  input  logic [FRAM_DW-1:0] fram_dq_i
);

  localparam int CW = $clog2(max3(TAS_CYC, TCA_CYC, TPC_CYC) + 1);

  state_t             state_reg, state_next;
  logic               tmr_load;
  logic [CW-1:0]      tmr_val;
  logic               tmr_done;

  logic               op_we_reg;
  logic [1:0]         op_be_reg;
  logic               ce_n_reg, we_n_reg, oe_n_reg, ub_n_reg, lb_n_reg;
  logic               dq_oe_reg;
  logic [FRAM_AW-1:0] addr_reg;
  logic [FRAM_DW-1:0] dq_o_reg;
  logic               rsp_valid_reg;
  logic [FRAM_DW-1:0] rsp_rdata_reg;

  fram_cyc_timer #(.W(CW)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (tmr_val),
    .done     (tmr_done)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    tmr_load   = 1'b0;
    tmr_val    = '0;
    case (state_reg)
      IDLE: begin
        if (bus.req_valid) begin
          state_next = SETUP;
          tmr_load   = 1'b1;
          tmr_val    = CW'(TAS_CYC - 1);
        end
      end
      SETUP: begin
        if (tmr_done) begin
          state_next = ACCESS;
          tmr_load   = 1'b1;
          tmr_val    = CW'(TCA_CYC - 1);
        end
      end
      ACCESS: begin
        if (tmr_done) begin
          state_next = HOLD;
        end
      end
      HOLD: begin
        state_next = PRECHARGE;
        tmr_load   = 1'b1;
        tmr_val    = CW'(TPC_CYC - 1);
      end
      PRECHARGE: begin
        if (tmr_done) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Pin registers change on the same edges as the state, so each pin value
  // appears exactly in the cycles of the state it belongs to.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_we_reg     <= 1'b0;
      op_be_reg     <= 2'b00;
      ce_n_reg      <= 1'b1;
      we_n_reg      <= 1'b1;
      oe_n_reg      <= 1'b1;
      ub_n_reg      <= 1'b1;
      lb_n_reg      <= 1'b1;
      dq_oe_reg     <= 1'b0;
      addr_reg      <= '0;
      dq_o_reg      <= '0;
      rsp_valid_reg <= 1'b0;
      rsp_rdata_reg <= '0;
    end else begin
      rsp_valid_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (bus.req_valid) begin
            op_we_reg <= bus.req_we;
            op_be_reg <= bus.req_be;
            addr_reg  <= bus.req_addr;
            dq_oe_reg <= bus.req_we;
            if (bus.req_we) begin
              dq_o_reg <= bus.req_wdata;
            end
          end
        end
        SETUP: begin
          if (tmr_done) begin
            ce_n_reg <= 1'b0;
            we_n_reg <= ~op_we_reg;
            oe_n_reg <= op_we_reg;
            ub_n_reg <= op_we_reg ? ~op_be_reg[1] : 1'b0;
            lb_n_reg <= op_we_reg ? ~op_be_reg[0] : 1'b0;
          end
        end
        ACCESS: begin
          if (tmr_done) begin
            ce_n_reg      <= 1'b1;
            we_n_reg      <= 1'b1;
            oe_n_reg      <= 1'b1;
            rsp_valid_reg <= 1'b1;
            if (!op_we_reg) begin
              rsp_rdata_reg <= fram_dq_i;
            end
          end
        end
        HOLD: begin
          dq_oe_reg <= 1'b0;
          ub_n_reg  <= 1'b1;
          lb_n_reg  <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.req_ready = (state_reg == IDLE);
  assign bus.rsp_valid = rsp_valid_reg;
  assign bus.rsp_rdata = rsp_rdata_reg;
  assign fram_ce_n     = ce_n_reg;
  assign fram_we_n     = we_n_reg;
  assign fram_oe_n     = oe_n_reg;
  assign fram_ub_n     = ub_n_reg;
  assign fram_lb_n     = lb_n_reg;
  assign fram_addr     = addr_reg;
  assign fram_dq_o     = dq_o_reg;
  assign fram_dq_oe    = dq_oe_reg;

endmodule

// File: tb/tb_fram_ctrl.sv
// Self-checking bench for fram_ctrl with a simple F-RAM device model on the pins
// and a per-cycle expectation derived from op phase timing.
module tb_fram_ctrl;
  import fram_ctrl_pkg::*;

  localparam int TAS    = 1;
  localparam int TCA    = 7;
  localparam int TPC    = 6;
  localparam int HOLD_J = TAS + TCA + 1;
  localparam int OCC    = TAS + TCA + 1 + TPC + 1;

  logic        clk = 1'b0;
  logic        rst;
  logic        ce_n, we_n, oe_n, ub_n, lb_n, dq_oe;
  logic [15:0] addr, dq_o, dq_i;

  always #5 clk = ~clk;

  fram_ctrl_if bus ();

  fram_ctrl #(.TAS_CYC(TAS), .TCA_CYC(TCA), .TPC_CYC(TPC)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .fram_ce_n  (ce_n),
    .fram_we_n  (we_n),
    .fram_oe_n  (oe_n),
    .fram_ub_n  (ub_n),
    .fram_lb_n  (lb_n),
    .fram_addr  (addr),
    .fram_dq_o  (dq_o),
    .fram_dq_oe (dq_oe),
    .fram_dq_i  (dq_i)
  );

  // Device model: erased words read 0xFFFF, bytes written while CE and WE are low.
  logic [15:0] dev_mem [0:65535];
  logic        dev_clear;

  always @(posedge clk) begin
    if (dev_clear) begin
      for (int i = 0; i < 65536; i++) dev_mem[i] <= 16'hFFFF;
    end else if (!ce_n && !we_n && dq_oe) begin
      if (!ub_n) dev_mem[addr][15:8] <= dq_o[15:8];
      if (!lb_n) dev_mem[addr][7:0]  <= dq_o[7:0];
    end
  end

  always_comb begin
    dq_i = 16'h0000;
    if (!ce_n && !oe_n && we_n) begin
      dq_i = {ub_n ? 8'h00 : dev_mem[addr][15:8], lb_n ? 8'h00 : dev_mem[addr][7:0]};
    end
  end

  int          checks   = 0;
  int          failures = 0;
  logic [15:0] ref_mem [0:65535];
  logic [15:0] m_addr, m_dq, m_rdata;
  logic        prev_rv;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s obs=%h exp=%h t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic mon_check();
    chk("oe_dqoe_excl", {31'd0, (!oe_n && dq_oe)}, 32'd0);
    chk("rsp_double", {31'd0, (bus.rsp_valid && prev_rv)}, 32'd0);
    prev_rv = bus.rsp_valid;
  endtask

  task automatic idle_pins_check(input logic ready_exp);
    chk("pins_idle", {26'd0, ce_n, we_n, oe_n, ub_n, lb_n, dq_oe}, 32'b111110);
    chk("addr", {16'd0, addr}, {16'd0, m_addr});
    chk("dq_o", {16'd0, dq_o}, {16'd0, m_dq});
    chk("rdata", {16'd0, bus.rsp_rdata}, {16'd0, m_rdata});
    chk("rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
    chk("ready", {31'd0, bus.req_ready}, {31'd0, ready_exp});
    mon_check();
  endtask

  task automatic cyc_check(input int j, input bit we, input logic [1:0] be);
    bit   acc, hold;
    logic e_ce, e_we, e_oe, e_ub, e_lb, e_dqoe;
    acc    = (j > TAS) && (j <= TAS + TCA);
    hold   = (j == HOLD_J);
    e_ce   = !acc;
    e_we   = !(acc && we);
    e_oe   = !(acc && !we);
    e_ub   = (acc || hold) ? (we ? ~be[1] : 1'b0) : 1'b1;
    e_lb   = (acc || hold) ? (we ? ~be[0] : 1'b0) : 1'b1;
    e_dqoe = we && (j <= HOLD_J);
    chk($sformatf("pins_j%0d", j), {26'd0, ce_n, we_n, oe_n, ub_n, lb_n, dq_oe},
        {26'd0, e_ce, e_we, e_oe, e_ub, e_lb, e_dqoe});
    chk("addr", {16'd0, addr}, {16'd0, m_addr});
    chk("dq_o", {16'd0, dq_o}, {16'd0, m_dq});
    chk("rdata", {16'd0, bus.rsp_rdata}, {16'd0, m_rdata});
    chk($sformatf("rsp_valid_j%0d", j), {31'd0, bus.rsp_valid}, {31'd0, hold});
    chk($sformatf("ready_j%0d", j), {31'd0, bus.req_ready}, {31'd0, (j == OCC)});
    mon_check();
  endtask

  task automatic reset_model();
    m_addr  = '0;
    m_dq    = '0;
    m_rdata = '0;
  endtask

  // Called at a negedge with the controller idle; returns at a negedge with it idle.
  task automatic do_op(input bit we, input logic [15:0] a, input logic [15:0] wd,
                       input logic [1:0] be, input int cut_j);
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_addr  = a;
    bus.req_wdata = wd;
    bus.req_be    = be;
    @(posedge clk);
    m_addr = a;
    if (we) m_dq = wd;
    for (int j = 1; j <= OCC; j++) begin
      @(negedge clk);
      if (j == HOLD_J) begin
        if (we) ref_mem[a] = {be[1] ? wd[15:8] : ref_mem[a][15:8], be[0] ? wd[7:0] : ref_mem[a][7:0]};
        else    m_rdata    = ref_mem[a];
      end
      cyc_check(j, we, be);
      if (j == cut_j) begin
        rst           = 1'b1;
        bus.req_valid = 1'b0;
        @(negedge clk);
        reset_model();
        idle_pins_check(1'b1);
        rst = 1'b0;
        $display("op %s addr=%h wdata=%h be=%b cut by reset at cycle %0d", we ? "WR" : "RD", a, wd, be, j);
        return;
      end
      if (j < OCC) begin
        bus.req_valid = 1'($urandom);
        bus.req_we    = 1'($urandom);
        bus.req_addr  = 16'($urandom);
        bus.req_wdata = 16'($urandom);
        bus.req_be    = 2'($urandom);
      end else begin
        bus.req_valid = 1'b0;
      end
    end
    $display("op %s addr=%h wdata=%h be=%b rdata=%h", we ? "WR" : "RD", a, wd, be, bus.rsp_rdata);
  endtask

  task automatic idle_cycle();
    bus.req_valid = 1'b0;
    @(negedge clk);
    idle_pins_check(1'b1);
  endtask

  initial begin
    logic [15:0] a;
    bit          we;
    rst           = 1'b1;
    dev_clear     = 1'b1;
    prev_rv       = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.req_be    = '0;
    for (int i = 0; i < 65536; i++) ref_mem[i] = 16'hFFFF;
    reset_model();
    repeat (2) @(posedge clk);
    dev_clear = 1'b0;
    @(negedge clk);
    idle_pins_check(1'b1);
    rst = 1'b0;
    idle_cycle();

    do_op(1'b1, 16'h0005, 16'h1234, 2'b11, 0);
    do_op(1'b0, 16'h0005, 16'h0000, 2'b00, 0);
    chk("t1_rdata", {16'd0, bus.rsp_rdata}, 32'h1234);

    do_op(1'b1, 16'h0010, 16'hABCD, 2'b01, 0);
    do_op(1'b0, 16'h0010, 16'h0000, 2'b00, 0);
    chk("t2_be01", {16'd0, bus.rsp_rdata}, 32'hFFCD);
    do_op(1'b1, 16'h0010, 16'hABCD, 2'b10, 0);
    do_op(1'b0, 16'h0010, 16'h0000, 2'b00, 0);
    chk("t2_be10", {16'd0, bus.rsp_rdata}, 32'hABCD);

    for (int k = 0; k < 4; k++) do_op(1'b0, 16'h0005, 16'h0000, 2'b11, 0);

    do_op(1'b1, 16'h0020, 16'h5555, 2'b11, TAS + 3);
    idle_cycle();
    idle_cycle();

    do_op(1'b0, 16'hFFFF, 16'h0000, 2'b00, 0);
    chk("t5_erased", {16'd0, bus.rsp_rdata}, 32'hFFFF);
    do_op(1'b1, 16'h0001, 16'h0000, 2'b00, 0);
    do_op(1'b0, 16'h0001, 16'h0000, 2'b00, 0);
    chk("t5_be00", {16'd0, bus.rsp_rdata}, 32'hFFFF);

    for (int k = 0; k < 40; k++) begin
      we = 1'($urandom);
      a  = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'h0040 + 16'($urandom_range(0, 7));
      if (a == 16'h0020) a = 16'h0021;
      do_op(we, a, 16'($urandom), 2'($urandom), 0);
      repeat ($urandom_range(0, 2)) idle_cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
